// File: rtl/uart_music_loader.sv
// uart_music_loader
// Receives one song of note bytes over the UART byte stream, writes each
// note code into the note RAM, then answers with an ACK byte and hands the
// RAM over to the player. A long silence in the middle of an upload aborts
// it with a NAK byte. A reload pulse restarts the upload from any state.

module uart_music_loader #(
   parameter logic [7:0]  SIZE_MUSIC_MAX = 8'd83,
   parameter logic [7:0]  ACK_BYTE       = 8'd66,
   parameter logic [7:0]  NAK_BYTE       = 8'd69,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_data_valid,
   input  logic [7:0] rx_data_out,
   input  logic       reload,
   output logic       tx_data_valid,
   output logic [7:0] tx_data_in,
   output logic       mem_we,
   output logic [7:0] mem_waddr,
   output logic [4:0] mem_wdata,
   output logic       w_en,
   output logic       load_done
);

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      SEND_ACK = 2'd1,
      PLAY     = 2'd2,
      SEND_NAK = 2'd3
   } state_t;

   state_t      state;
   logic [7:0]  index;
   logic [23:0] gap_cnt;
   logic        song_full;
   logic        gap_expired;

   // Upload is complete once every note slot has been written; the gap
   // counter expires one cycle before it would reach the configured limit.
   always_comb begin
      song_full   = (index == SIZE_MUSIC_MAX);
      gap_expired = (gap_cnt == (TIMEOUT_CYCLES - 24'd1));
   end

   // Loader FSM with registered RAM-write, handshake and mode outputs.
   // An incoming byte wins over an expiring gap counter, reload wins over both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= LOAD;
         index         <= 8'd0;
         gap_cnt       <= 24'd0;
         w_en          <= 1'b1;
         load_done     <= 1'b0;
         mem_we        <= 1'b0;
         mem_waddr     <= 8'd0;
         mem_wdata     <= 5'd0;
         tx_data_valid <= 1'b0;
         tx_data_in    <= 8'd0;
      end else begin
         mem_we        <= 1'b0;
         tx_data_valid <= 1'b0;
         if (reload) begin
            state     <= LOAD;
            index     <= 8'd0;
            gap_cnt   <= 24'd0;
            load_done <= 1'b0;
            w_en      <= 1'b1;
         end else begin
            case (state)
               LOAD: begin
                  if (song_full) begin
                     state         <= SEND_ACK;
                     gap_cnt       <= 24'd0;
                     tx_data_valid <= 1'b1;
                     tx_data_in    <= ACK_BYTE;
                  end else if (rx_data_valid) begin
                     mem_we    <= 1'b1;
                     mem_waddr <= index;
                     mem_wdata <= rx_data_out[4:0];
                     index     <= index + 8'd1;
                     gap_cnt   <= 24'd0;
                  end else if (index != 8'd0) begin
                     if (gap_expired) begin
                        state         <= SEND_NAK;
                        index         <= 8'd0;
                        gap_cnt       <= 24'd0;
                        tx_data_valid <= 1'b1;
                        tx_data_in    <= NAK_BYTE;
                     end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                     end
                  end
               end
               SEND_ACK: begin
                  state     <= PLAY;
                  w_en      <= 1'b0;
                  load_done <= 1'b1;
               end
               PLAY: begin
                  state <= PLAY;
               end
               SEND_NAK: begin
                  state <= LOAD;
               end
               default: begin
                  state <= LOAD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_music_loader.sv
// tb_uart_music_loader
// Directed bench for the song loader: full uploads, extra bytes in playback,
// gap timeout and NAK, reload while playing and mid-upload, reset mid-upload.

module tb_uart_music_loader;

   logic       clk;
   logic       rst_n;
   logic       rx_data_valid;
   logic [7:0] rx_data_out;
   logic       reload;
   logic       tx_data_valid;
   logic [7:0] tx_data_in;
   logic       mem_we;
   logic [7:0] mem_waddr;
   logic [4:0] mem_wdata;
   logic       w_en;
   logic       load_done;

   int vectors;
   int miscompares;
   int txCount;
   int consecTx;
   int writeCount;
   int txExpected;
   int writesExpected;
   bit prevTx;

   uart_music_loader #(
      .SIZE_MUSIC_MAX(8'd83),
      .ACK_BYTE      (8'd66),
      .NAK_BYTE      (8'd69),
      .TIMEOUT_CYCLES(24'd1000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data_valid(rx_data_valid),
      .rx_data_out  (rx_data_out),
      .reload       (reload),
      .tx_data_valid(tx_data_valid),
      .tx_data_in   (tx_data_in),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .w_en         (w_en),
      .load_done    (load_done)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count tx strobes, back-to-back strobes and RAM writes as they happen
   initial begin
      txCount    = 0;
      consecTx   = 0;
      writeCount = 0;
      prevTx     = 1'b0;
   end
   always @(negedge clk) begin
      if (tx_data_valid === 1'b1) begin
         txCount++;
         if (prevTx) consecTx++;
      end
      prevTx = (tx_data_valid === 1'b1);
      if (mem_we === 1'b1) writeCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counters are compared a moment after the edge so the monitor has updated
   task automatic checkCounts(input string tag);
      #1;
      checkOutput({tag, " txCount"}, txCount, txExpected);
      checkOutput({tag, " writeCount"}, writeCount, writesExpected);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " w_en"}, w_en, 1);
      checkOutput({tag, " load_done"}, load_done, 0);
      checkOutput({tag, " mem_we"}, mem_we, 0);
      checkOutput({tag, " mem_waddr"}, mem_waddr, 0);
      checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, " tx_valid"}, tx_data_valid, 0);
      checkOutput({tag, " tx_data"}, tx_data_in, 0);
   endtask

   // Present one byte for one cycle and check the write that should follow
   task automatic applyStimulus(input logic [7:0] b, input bit expectWrite, input logic [7:0] expAddr, input string tag);
      rx_data_valid = 1'b1;
      rx_data_out   = b;
      @(negedge clk);
      rx_data_valid = 1'b0;
      checkOutput({tag, " mem_we"}, mem_we, expectWrite);
      if (expectWrite) begin
         writesExpected++;
         checkOutput({tag, " mem_waddr"}, mem_waddr, expAddr);
         checkOutput({tag, " mem_wdata"}, mem_wdata, {27'd0, b[4:0]});
      end
   endtask

   task automatic pulseReload(input string tag);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      checkOutput({tag, " load_done"}, load_done, 0);
      checkOutput({tag, " w_en"}, w_en, 1);
      checkOutput({tag, " tx_valid"}, tx_data_valid, 0);
   endtask

   // Full 83-note upload followed by the ACK handshake and hand-over to PLAY
   task automatic uploadSong(input bit allOnes, input int gap, input string tag);
      logic [7:0] b;
      for (int i = 0; i < 83; i++) begin
         b = allOnes ? 8'hFF : 8'(i);
         applyStimulus(b, 1'b1, 8'(i), tag);
         if (i < 82) idle(gap - 1);
      end
      checkOutput({tag, " pre-ack tx_valid"}, tx_data_valid, 0);
      @(negedge clk);
      checkOutput({tag, " ack tx_valid"}, tx_data_valid, 1);
      checkOutput({tag, " ack tx_data"}, tx_data_in, 8'd66);
      checkOutput({tag, " ack w_en"}, w_en, 1);
      txExpected++;
      @(negedge clk);
      checkOutput({tag, " play tx_valid"}, tx_data_valid, 0);
      checkOutput({tag, " play tx_data held"}, tx_data_in, 8'd66);
      checkOutput({tag, " play w_en"}, w_en, 0);
      checkOutput({tag, " play load_done"}, load_done, 1);
      checkCounts(tag);
   endtask

   // Directed sequence
   initial begin
      vectors        = 0;
      miscompares    = 0;
      txExpected     = 0;
      writesExpected = 0;
      rst_n          = 1'b0;
      rx_data_valid  = 1'b0;
      rx_data_out    = 8'd0;
      reload         = 1'b0;

      idle(2);
      checkResetValues("reset");
      rst_n = 1'b1;
      idle(2);
      checkResetValues("post-reset idle");

      // Complete upload of bytes 0..82 at 100-cycle spacing
      uploadSong(1'b0, 100, "upload1");

      // Bytes arriving in PLAY are ignored
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'hA0 + 8'(i), 1'b0, 8'd0, "play-extra");
         idle(99);
      end
      checkOutput("play-extra load_done", load_done, 1);
      checkOutput("play-extra w_en", w_en, 0);
      checkCounts("play-extra");

      // Back to LOAD, then a partial upload that times out
      pulseReload("reload-to");
      applyStimulus(8'h10, 1'b1, 8'd0, "to-b0");
      idle(999);
      applyStimulus(8'h11, 1'b1, 8'd1, "to-coincident");
      checkOutput("to-coincident tx_valid", tx_data_valid, 0);
      for (int i = 2; i < 5; i++) begin
         idle(99);
         applyStimulus(8'h10 + 8'(i), 1'b1, 8'(i), "to-b");
      end
      idle(999);
      checkOutput("to-before tx_valid", tx_data_valid, 0);
      @(negedge clk);
      checkOutput("nak tx_valid", tx_data_valid, 1);
      checkOutput("nak tx_data", tx_data_in, 8'd69);
      txExpected++;
      @(negedge clk);
      checkOutput("post-nak tx_valid", tx_data_valid, 0);
      checkOutput("post-nak w_en", w_en, 1);
      checkOutput("post-nak load_done", load_done, 0);
      checkCounts("nak");
      idle(5);
      uploadSong(1'b0, 100, "upload-after-nak");

      // Reload in PLAY, then an all-ones song
      pulseReload("reload-play");
      uploadSong(1'b1, 100, "upload-ff");

      // Reload coincident with a byte at index 40
      pulseReload("reload-mid");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'(i), 1'b1, 8'(i), "mid");
         idle(9);
      end
      rx_data_valid = 1'b1;
      rx_data_out   = 8'h28;
      reload        = 1'b1;
      @(negedge clk);
      rx_data_valid = 1'b0;
      reload        = 1'b0;
      checkOutput("reload+rx mem_we", mem_we, 0);
      checkOutput("reload+rx tx_valid", tx_data_valid, 0);
      idle(5);
      applyStimulus(8'h07, 1'b1, 8'd0, "after-reload");

      // Reset at index 50 throws the partial song away
      for (int i = 1; i < 50; i++) begin
         idle(9);
         applyStimulus(8'(i), 1'b1, 8'(i), "pre-rst");
      end
      idle(3);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetValues("mid-reset");
      idle(3);
      rst_n = 1'b1;
      idle(3);
      checkResetValues("after-mid-reset");
      checkCounts("after-mid-reset");
      uploadSong(1'b0, 10, "upload-after-reset");

      checkOutput("consecutive tx strobes", consecTx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
